// File: rtl/proc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_seq_pkg
// Description : Shared types and constants for the instruction sequencer:
//               FSM state encoding, parameter defaults, processor opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_seq_pkg;

  localparam int AW_DEF      = 5;
  localparam int TIMEOUT_DEF = 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_HOLD   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  // Processor opcodes live in DIN[15:13]
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

endpackage
`default_nettype wire

// File: rtl/proc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_sequencer_if
// Description : ROM read bus plus processor issue/complete handshake seen by
//               the sequencer (master) and the ROM/processor side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_sequencer_if
  import proc_seq_pkg::*;
#(
  parameter int AW = AW_DEF
) ();

  logic [AW-1:0] MemAddr;
  logic          MemRd;
  logic [15:0]   MemData;
  logic [15:0]   DIN;
  logic          Run;
  logic          Done;

  modport master (output MemAddr, MemRd, DIN, Run, input MemData, Done);
  modport slave  (input MemAddr, MemRd, DIN, Run, output MemData, Done);

endinterface
`default_nettype wire

// File: rtl/proc_seq_wdog.sv
`default_nettype none
// ============================================================================
// Module      : proc_seq_wdog
// Description : Clearable up-counter that flags a processor which never
//               returns Done within TIMEOUT wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_seq_wdog
  import proc_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  wire logic Clock,
  input  wire logic Resetn,
  input  wire logic Clr,
  input  wire logic Inc,
  output logic      Expire
);

  localparam int           c_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT - 1);
  localparam logic [c_W-1:0] c_MAX  = c_W'(TIMEOUT);

  logic [c_W-1:0] r_count;

  // Count idle wait cycles; saturate so a stuck count can never wrap
  always_ff @(posedge Clock) begin
    if (!Resetn || Clr)                 r_count <= '0;
    else if (Inc && (r_count != c_MAX)) r_count <= r_count + 1'b1;
  end

  // Fires on the cycle whose increment makes the count reach TIMEOUT
  assign Expire = Inc && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/regn.sv
`default_nettype none
// ============================================================================
// Module      : regn
// Description : N-bit load-enable holding register with synchronous
//               active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module regn #(
  parameter int N = 16
) (
  input  wire logic         Clock,
  input  wire logic         Resetn,
  input  wire logic         Rin,
  input  wire logic [N-1:0] R,
  output logic      [N-1:0] Q
);

  // Capture R whenever the load enable is high
  always_ff @(posedge Clock) begin
    if (!Resetn)  Q <= '0;
    else if (Rin) Q <= R;
  end

endmodule
`default_nettype wire

// File: rtl/proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : proc_sequencer
// Description : Fetches a run of instruction words from a synchronous ROM,
//               issues each to the processor with a Run pulse and waits for
//               Done, with pause, status and a hung-processor watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  wire logic          Clock,
  input  wire logic          Resetn,
  input  wire logic          Start,
  input  wire logic [AW-1:0] StartAddr,
  input  wire logic [AW:0]   Length,
  input  wire logic          Pause,
  proc_sequencer_if.master   bus,
  output logic               Busy,
  output logic               Finished,
  output logic               Error,
  output logic [AW:0]        IssueCount
);

  localparam logic [AW:0] c_ONE = (AW + 1)'(1);

  state_t        r_state, w_next;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_rem;
  logic [AW:0]   r_issue;
  logic          r_error;
  logic          w_start_acc, w_done_acc, w_expire;
  logic          w_wd_clr, w_wd_inc;

  assign w_start_acc = (r_state == S_IDLE) && Start;
  assign w_done_acc  = (r_state == S_WAIT) && bus.Done;
  assign w_wd_clr    = (r_state == S_ISSUE);
  assign w_wd_inc    = (r_state == S_WAIT) && !bus.Done;

  proc_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Clr    (w_wd_clr),
    .Inc    (w_wd_inc),
    .Expire (w_expire)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode; Pause is only looked at on instruction boundaries
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (Length == '0) w_next = S_FINISH;
          else if (Pause)   w_next = S_HOLD;
          else              w_next = S_FETCH;
        end
      end
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        // Done takes priority over a simultaneous watchdog expiry
        if (bus.Done) begin
          if (r_rem == c_ONE) w_next = S_FINISH;
          else if (Pause)     w_next = S_HOLD;
          else                w_next = S_FETCH;
        end else if (w_expire) begin
          w_next = S_IDLE;
        end
      end
      S_HOLD:   if (!Pause) w_next = S_FETCH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Run bookkeeping: PC, remaining count, completed count, sticky error
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_pc    <= '0;
      r_rem   <= '0;
      r_issue <= '0;
      r_error <= 1'b0;
    end else if (w_start_acc) begin
      r_pc    <= StartAddr;
      r_rem   <= Length;
      r_issue <= '0;
      r_error <= 1'b0;
    end else if (w_done_acc) begin
      r_pc    <= r_pc + 1'b1;
      r_rem   <= r_rem - 1'b1;
      r_issue <= r_issue + 1'b1;
    end else if (w_expire) begin
      r_error <= 1'b1;
    end
  end

  // Instruction word is held stable from LOAD through the whole issue
  regn #(.N(16)) u_din (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Rin    (r_state == S_LOAD),
    .R      (bus.MemData),
    .Q      (bus.DIN)
  );

  assign bus.MemAddr = r_pc;
  assign bus.MemRd   = (r_state == S_FETCH);
  assign bus.Run     = (r_state == S_ISSUE);
  assign Busy        = (r_state != S_IDLE);
  assign Finished    = (r_state == S_FINISH);
  assign Error       = r_error;
  assign IssueCount  = r_issue;

endmodule
`default_nettype wire
